// File: rtl/screen_pkg.sv
// Screen geometry, pixel format and painter state encoding shared by the
// rectangle painter and the framebuffer reader.
package screen_pkg;

    localparam int SCREEN_WIDTH     = 112;
    localparam int SCREEN_HEIGHT    = 112;
    localparam int PIXEL_COLOR_SIZE = 3;
    localparam int FB_ADDR_SIZE     = 14;
    localparam int COORD_SIZE       = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLIP  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } paint_state_t;

endpackage

// File: rtl/coor_to_offset.sv
// Linear framebuffer offset of pixel (x, y): x + y * SCR_WIDTH.
module coor_to_offset
    import screen_pkg::*;
#(
    parameter int SCR_WIDTH = SCREEN_WIDTH,
    parameter int ADDR_SIZE = FB_ADDR_SIZE
) (
    input  logic [COORD_SIZE-1:0] i_x,
    input  logic [COORD_SIZE-1:0] i_y,
    output logic [ADDR_SIZE-1:0]  o_offset
);

    localparam logic [ADDR_SIZE-1:0] ROW_STRIDE = ADDR_SIZE'(SCR_WIDTH);

    always_comb begin
        o_offset = ADDR_SIZE'(i_x) + ADDR_SIZE'(i_y) * ROW_STRIDE;
    end

endmodule

// File: rtl/rect_painter.sv
// Fills a screen-clipped rectangle into the framebuffer one pixel per accepted
// write, in raster order, with a start/finish continuation handshake.
module rect_painter
    import screen_pkg::*;
#(
    parameter int SCR_WIDTH  = SCREEN_WIDTH,
    parameter int SCR_HEIGHT = SCREEN_HEIGHT,
    parameter int COLOR_SIZE = PIXEL_COLOR_SIZE,
    parameter int ADDR_SIZE  = FB_ADDR_SIZE
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  in_cont_signal,
    input  logic [COORD_SIZE-1:0] rect_x,
    input  logic [COORD_SIZE-1:0] rect_y,
    input  logic [COORD_SIZE-1:0] rect_w,
    input  logic [COORD_SIZE-1:0] rect_h,
    input  logic [COLOR_SIZE-1:0] rect_color,
    output logic [ADDR_SIZE-1:0]  write_addr,
    output logic [COLOR_SIZE-1:0] write_data,
    output logic                  write_en,
    input  logic                  write_ready,
    output logic                  busy,
    output logic                  out_cont_signal,
    input  logic                  next_fin_signal
);

    localparam int SUM_SIZE = COORD_SIZE + 1;
    localparam logic [SUM_SIZE-1:0] SCR_W_S = SUM_SIZE'(SCR_WIDTH);
    localparam logic [SUM_SIZE-1:0] SCR_H_S = SUM_SIZE'(SCR_HEIGHT);

    paint_state_t          r_state;
    paint_state_t          w_next_state;

    logic [COORD_SIZE-1:0] r_x, r_y, r_w, r_h;
    logic [COLOR_SIZE-1:0] r_color;
    logic [SUM_SIZE-1:0]   r_x_end, r_y_end;
    logic [COORD_SIZE-1:0] r_cx, r_cy;

    logic [SUM_SIZE-1:0]   w_x_sum, w_y_sum, w_x_end, w_y_end;
    logic [SUM_SIZE-1:0]   w_cx_inc, w_cy_inc;
    logic                  w_empty, w_accept, w_row_end, w_last;

    // One extra bit keeps x+w and y+h from wrapping before the clip.
    assign w_x_sum = {1'b0, r_x} + {1'b0, r_w};
    assign w_y_sum = {1'b0, r_y} + {1'b0, r_h};
    assign w_x_end = (w_x_sum > SCR_W_S) ? SCR_W_S : w_x_sum;
    assign w_y_end = (w_y_sum > SCR_H_S) ? SCR_H_S : w_y_sum;
    assign w_empty = (r_w == '0) || (r_h == '0) ||
                     ({1'b0, r_x} >= SCR_W_S) || ({1'b0, r_y} >= SCR_H_S);

    assign w_accept  = (r_state == ST_WRITE) && write_ready;
    assign w_cx_inc  = {1'b0, r_cx} + SUM_SIZE'(1);
    assign w_cy_inc  = {1'b0, r_cy} + SUM_SIZE'(1);
    assign w_row_end = (w_cx_inc == r_x_end);
    assign w_last    = w_row_end && (w_cy_inc == r_y_end);

    always_ff @(posedge Clck) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (in_cont_signal) w_next_state = ST_CLIP;
            ST_CLIP:  w_next_state = w_empty ? ST_DONE : ST_WRITE;
            ST_WRITE: if (w_accept && w_last) w_next_state = ST_DONE;
            ST_DONE:  if (next_fin_signal) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_cont_signal) begin
                        r_x     <= rect_x;
                        r_y     <= rect_y;
                        r_w     <= rect_w;
                        r_h     <= rect_h;
                        r_color <= rect_color;
                    end
                end
                ST_CLIP: begin
                    r_x_end <= w_x_end;
                    r_y_end <= w_y_end;
                    r_cx    <= r_x;
                    r_cy    <= r_y;
                end
                ST_WRITE: begin
                    if (w_accept) begin
                        if (w_row_end) begin
                            r_cx <= r_x;
                            r_cy <= r_cy + COORD_SIZE'(1);
                        end else begin
                            r_cx <= r_cx + COORD_SIZE'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    coor_to_offset #(
        .SCR_WIDTH (SCR_WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_offset (
        .i_x      (r_cx),
        .i_y      (r_cy),
        .o_offset (write_addr)
    );

    // Reset also masks the request combinationally so no write lands on the reset edge.
    always_comb begin
        write_en        = (r_state == ST_WRITE) && !Reset;
        write_data      = r_color;
        busy            = (r_state != ST_IDLE);
        out_cont_signal = (r_state == ST_DONE);
    end

endmodule

// File: tb/tb_rect_painter.sv
// Randomised bench for rect_painter against a pixel-list model of the clipped fill.
module tb_rect_painter;

    localparam int SW = 112;
    localparam int SH = 112;

    logic       Clck = 1'b0;
    logic       Reset;
    logic       in_cont_signal;
    logic [6:0] rect_x, rect_y, rect_w, rect_h;
    logic [2:0] rect_color;
    logic [13:0] write_addr;
    logic [2:0] write_data;
    logic       write_en;
    logic       write_ready;
    logic       busy;
    logic       out_cont_signal;
    logic       next_fin_signal;

    int tests_run = 0;
    int tests_failed = 0;

    rect_painter dut (
        .Clck            (Clck),
        .Reset           (Reset),
        .in_cont_signal  (in_cont_signal),
        .rect_x          (rect_x),
        .rect_y          (rect_y),
        .rect_w          (rect_w),
        .rect_h          (rect_h),
        .rect_color      (rect_color),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .write_en        (write_en),
        .write_ready     (write_ready),
        .busy            (busy),
        .out_cont_signal (out_cont_signal),
        .next_fin_signal (next_fin_signal)
    );

    always #5 Clck = ~Clck;

    // rmode: 0 = always ready, 1 = ready toggles 0/1, 2 = random ready.
    task automatic run_fill(input int x, input int y, input int w, input int h,
                            input int c, input int rmode, input int hold, input bit release_done);
        int xe, ye, cycles, ridx;
        int exp_addr[$];
        int got_addr[$];
        int got_data[$];
        bit pending, last_accept, rdy;
        int prev_addr;
        xe = (x + w > SW) ? SW : x + w;
        ye = (y + h > SH) ? SH : y + h;
        if (w != 0 && h != 0 && x < SW && y < SH)
            for (int yy = y; yy < ye; yy++)
                for (int xx = x; xx < xe; xx++)
                    exp_addr.push_back(xx + yy * SW);

        rect_x = 7'(x); rect_y = 7'(y); rect_w = 7'(w); rect_h = 7'(h);
        rect_color = 3'(c); in_cont_signal = 1'b1; write_ready = 1'b0;
        @(negedge Clck);
        in_cont_signal = 1'b0;
        rect_x = 7'($urandom); rect_y = 7'($urandom);
        rect_w = 7'($urandom); rect_h = 7'($urandom); rect_color = 3'($urandom);
        tests_run++;
        if (write_en !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clip_cycle: write_en=%b busy=%b, required 0/1", write_en, busy);
        end
        @(negedge Clck);
        tests_run++;
        if (exp_addr.size() == 0) begin
            if (out_cont_signal !== 1'b1 || write_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_done_latency: out_cont=%b write_en=%b, required 1/0",
                         out_cont_signal, write_en);
            end
        end else if (write_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_write_latency: write_en=%b, required 1", write_en);
        end

        cycles = 0; pending = 1'b0; last_accept = 1'b0; prev_addr = 0; ridx = 0;
        while (out_cont_signal !== 1'b1 && cycles < 2000) begin
            last_accept = 1'b0;
            if (write_en === 1'b1) begin
                if (pending) begin
                    tests_run++;
                    if (int'(write_addr) !== prev_addr) begin
                        tests_failed++;
                        $display("FAIL addr_hold: write_addr=%0d, required %0d", write_addr, prev_addr);
                    end
                end
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = ridx[0];
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                ridx++;
                write_ready = rdy;
                if (rdy) begin
                    got_addr.push_back(int'(write_addr));
                    got_data.push_back(int'(write_data));
                end
                pending = !rdy;
                last_accept = rdy;
                prev_addr = int'(write_addr);
            end else begin
                write_ready = 1'b0;
            end
            @(negedge Clck);
            cycles++;
        end
        write_ready = 1'b0;

        tests_run++;
        if (cycles >= 2000) begin
            tests_failed++;
            $display("FAIL fill_timeout: out_cont=%b after %0d cycles, required 1", out_cont_signal, cycles);
        end
        if (exp_addr.size() != 0) begin
            tests_run++;
            if (!last_accept || write_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_after_last: last_accept=%b write_en=%b, required 1/0",
                         last_accept, write_en);
            end
        end
        tests_run++;
        if (got_addr.size() != exp_addr.size()) begin
            tests_failed++;
            $display("FAIL write_count: got %0d writes, required %0d", got_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                tests_run++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== c) begin
                    tests_failed++;
                    $display("FAIL write_%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                             i, got_addr[i], got_data[i], exp_addr[i], c);
                end
            end
        end
        $display("[TB] fill x=%0d y=%0d w=%0d h=%0d c=%0d mode=%0d -> %0d writes (model %0d)",
                 x, y, w, h, c, rmode, got_addr.size(), exp_addr.size());

        for (int i = 0; i < hold; i++) begin
            @(negedge Clck);
            tests_run++;
            if (out_cont_signal !== 1'b1 || write_en !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL done_hold: out_cont=%b write_en=%b busy=%b, required 1/0/1",
                         out_cont_signal, write_en, busy);
            end
        end
        if (release_done) begin
            next_fin_signal = 1'b1;
            @(negedge Clck);
            next_fin_signal = 1'b0;
            tests_run++;
            if (busy !== 1'b0 || out_cont_signal !== 1'b0) begin
                tests_failed++;
                $display("FAIL release: busy=%b out_cont=%b, required 0/0", busy, out_cont_signal);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; in_cont_signal = 1'b1; next_fin_signal = 1'b0; write_ready = 1'b1;
        rect_x = 7'd3; rect_y = 7'd4; rect_w = 7'd5; rect_h = 7'd6; rect_color = 3'd7;
        repeat (3) @(negedge Clck);
        tests_run++;
        if (write_en !== 1'b0 || busy !== 1'b0 || out_cont_signal !== 1'b0 ||
            write_addr !== 14'd0 || write_data !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state: en=%b busy=%b oc=%b addr=%0d data=%0d, required all 0",
                     write_en, busy, out_cont_signal, write_addr, write_data);
        end
        Reset = 1'b0; in_cont_signal = 1'b0; write_ready = 1'b0;
        @(negedge Clck);
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        run_fill(10, 20, 3, 2, 5, 0, 2, 1'b1);
    endtask

    task automatic test_clip();
        run_fill(110, 111, 5, 4, 6, 0, 1, 1'b1);
    endtask

    task automatic test_empty();
        run_fill(40, 40, 0, 9, 2, 0, 1, 1'b1);
        run_fill(112, 5, 4, 4, 3, 0, 1, 1'b1);
    endtask

    task automatic test_ready_toggle();
        run_fill(50, 60, 4, 1, 1, 1, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int accepted;
        int tmo;
        rect_x = 7'd5; rect_y = 7'd5; rect_w = 7'd8; rect_h = 7'd8; rect_color = 3'd4;
        in_cont_signal = 1'b1;
        @(negedge Clck);
        in_cont_signal = 1'b0;
        accepted = 0; tmo = 0;
        while (accepted < 3 && tmo < 50) begin
            @(negedge Clck);
            tmo++;
            if (write_en === 1'b1) begin
                write_ready = 1'b1;
                accepted++;
            end
        end
        @(negedge Clck);
        Reset = 1'b1; write_ready = 1'b1;
        #1;
        tests_run++;
        if (write_en !== 1'b0 || accepted != 3) begin
            tests_failed++;
            $display("FAIL reset_masks_write: write_en=%b accepted=%0d, required 0/3", write_en, accepted);
        end
        @(negedge Clck);
        Reset = 1'b0; write_ready = 1'b0;
        tests_run++;
        if (write_en !== 1'b0 || busy !== 1'b0 || out_cont_signal !== 1'b0 || write_addr !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_write: en=%b busy=%b oc=%b addr=%0d, required 0/0/0/0",
                     write_en, busy, out_cont_signal, write_addr);
        end
        $display("[TB] reset mid-write after %0d writes", accepted);
        run_fill(20, 30, 2, 2, 3, 0, 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_fill(7, 9, 3, 3, 2, 2, 10, 1'b0);
        next_fin_signal = 1'b1;
        in_cont_signal = 1'b1;
        @(negedge Clck);
        next_fin_signal = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || out_cont_signal !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_to_idle: busy=%b out_cont=%b, required 0/0", busy, out_cont_signal);
        end
        run_fill(100, 0, 20, 2, 6, 0, 1, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_fill(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                     int'($urandom_range(0, 7)), 2, int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_ready_toggle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
